// File: rtl/sd_clk_ctrl.sv
// rtl/sd_clk_ctrl.sv - SD clock PLL sequencer with lock debounce and glitch-free slow/fast mux switching
module sd_clk_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int SWITCH_GAP   = 8,
    parameter int CNT_W        = 13
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       pll_lock_i,
    input  logic       fast_req_i,
    output logic       pll_rst_o,
    output logic       clk_en_o,
    output logic       clk_sel_o,
    output logic       ready_o,
    output logic       sd_rstn_o,
    output logic [3:0] relock_cnt_o
);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        SET_SEL,
        RUN,
        GATE_OFF
    } state_t;

    localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(SWITCH_GAP - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_meta, lock_s;
    logic             cnt_zero;
    logic             go_rst, go_sel;
    logic             pll_rst_d, clk_en_d, clk_sel_d, ready_d, sd_rstn_d;
    logic [3:0]       relock_d, relock_sat;

    assign cnt_zero   = (cnt_q == '0);
    assign relock_sat = (relock_cnt_o == 4'hf) ? relock_cnt_o : relock_cnt_o + 4'h1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock_i;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= PLL_RST;
            cnt_q        <= RST_LOAD;
            pll_rst_o    <= 1'b1;
            clk_en_o     <= 1'b0;
            clk_sel_o    <= 1'b0;
            ready_o      <= 1'b0;
            sd_rstn_o    <= 1'b0;
            relock_cnt_o <= 4'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pll_rst_o    <= pll_rst_d;
            clk_en_o     <= clk_en_d;
            clk_sel_o    <= clk_sel_d;
            ready_o      <= ready_d;
            sd_rstn_o    <= sd_rstn_d;
            relock_cnt_o <= relock_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
        pll_rst_d = pll_rst_o;
        clk_en_d  = clk_en_o;
        clk_sel_d = clk_sel_o;
        ready_d   = ready_o;
        sd_rstn_d = sd_rstn_o;
        relock_d  = relock_cnt_o;
        go_rst    = 1'b0;
        go_sel    = 1'b0;

        case (state_q)
            PLL_RST: begin
                if (cnt_zero) begin
                    state_d   = WAIT_LOCK;
                    cnt_d     = TIMEOUT_LOAD;
                    pll_rst_d = 1'b0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = STABLE_LOAD;
                end else if (cnt_zero) begin
                    go_rst = 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TIMEOUT_LOAD;
                end else if (cnt_zero) begin
                    go_sel    = 1'b1;
                    sd_rstn_d = 1'b1;
                end
            end
            SET_SEL: begin
                if (!lock_s) begin
                    go_rst = 1'b1;
                end else if (cnt_zero) begin
                    state_d  = RUN;
                    clk_en_d = 1'b1;
                    ready_d  = 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    go_rst = 1'b1;
                end else if (fast_req_i != clk_sel_o) begin
                    state_d  = GATE_OFF;
                    cnt_d    = GAP_LOAD;
                    clk_en_d = 1'b0;
                    ready_d  = 1'b0;
                end
            end
            GATE_OFF: begin
                if (!lock_s) begin
                    go_rst = 1'b1;
                end else if (cnt_zero) begin
                    go_sel = 1'b1;
                end
            end
            default: begin
                state_d   = PLL_RST;
                cnt_d     = RST_LOAD;
                pll_rst_d = 1'b1;
                clk_en_d  = 1'b0;
                ready_d   = 1'b0;
            end
        endcase

        if (go_sel) begin
            state_d   = SET_SEL;
            cnt_d     = GAP_LOAD;
            clk_sel_d = fast_req_i;
        end

        if (go_rst) begin
            state_d   = PLL_RST;
            cnt_d     = RST_LOAD;
            pll_rst_d = 1'b1;
            clk_en_d  = 1'b0;
            ready_d   = 1'b0;
            relock_d  = relock_sat;
        end
    end

endmodule

// File: tb/tb_sd_clk_ctrl.sv
// tb/tb_sd_clk_ctrl.sv - scoreboard bench for sd_clk_ctrl
module tb_sd_clk_ctrl;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       pll_lock_i;
    logic       fast_req_i;
    logic       pll_rst_o;
    logic       clk_en_o;
    logic       clk_sel_o;
    logic       ready_o;
    logic       sd_rstn_o;
    logic [3:0] relock_cnt_o;

    sd_clk_ctrl dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .pll_lock_i   (pll_lock_i),
        .fast_req_i   (fast_req_i),
        .pll_rst_o    (pll_rst_o),
        .clk_en_o     (clk_en_o),
        .clk_sel_o    (clk_sel_o),
        .ready_o      (ready_o),
        .sd_rstn_o    (sd_rstn_o),
        .relock_cnt_o (relock_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [8:0] v;
        int         cyc;
        int         tol;
        string      nm;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e_m;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc;
    int         lcnt;
    int         k;
    logic       lock_en;
    logic       lock_kill;
    logic [8:0] prev;
    logic [8:0] ov;

    assign ov = {pll_rst_o, clk_en_o, clk_sel_o, ready_o, sd_rstn_o, relock_cnt_o};

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always @(posedge clk_i) begin
        #2;
        if (!rstn_i || pll_rst_o) lcnt <= 0;
        else if (lcnt < 100)      lcnt <= lcnt + 1;
    end

    assign pll_lock_i = (lcnt >= 30) && lock_en && !lock_kill;

    function automatic logic [8:0] vec(input bit pr, input bit en, input bit sel,
                                       input bit rdy, input bit sd, input int rc);
        logic [3:0] r4;
        r4 = 4'(rc);
        return {pr, en, sel, rdy, sd, r4};
    endfunction

    task automatic push(input logic [8:0] v, input int c, input int t, input string nm);
        exp_t e;
        e.v   = v;
        e.cyc = c;
        e.tol = t;
        e.nm  = nm;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic drain(input int budget, input string nm);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: %0d expected events still pending, want 0 within %0d cycles",
                     nm, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic switch_to(input bit val);
        step();
        k = cyc;
        fast_req_i = val;
        push(vec(0, 0, !val, 0, 1, 0), k + 1,  0, "switch_gate_off");
        push(vec(0, 0, val,  0, 1, 0), k + 9,  0, "switch_sel_change");
        push(vec(0, 1, val,  1, 1, 0), k + 17, 0, "switch_ready");
        drain(100, "switch");
    endtask

    initial begin
        prev = 'x;
        forever begin
            @(negedge clk_i or negedge rstn_i);
            #1;
            if (ov !== prev) begin
                if (prev[7] === 1'b1 && ov[7] === 1'b1) begin
                    n_cmp++;
                    if (ov[6] !== prev[6]) begin
                        n_bad++;
                        $display("FAIL sel_glitch: sel %b -> %b with clk_en=1 at cyc=%0d, want stable",
                                 prev[6], ov[6], cyc);
                    end
                end
                if (ov[7] === 1'b1) begin
                    n_cmp++;
                    if (ov[5] !== 1'b1) begin
                        n_bad++;
                        $display("FAIL en_implies_ready: ready=%b with clk_en=1 at cyc=%0d, want 1",
                                 ov[5], cyc);
                    end
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_change: got out=%b at cyc=%0d, want no change", ov, cyc);
                end else begin
                    e_m = exp_q.pop_front();
                    n_cmp++;
                    if (ov !== e_m.v) begin
                        n_bad++;
                        $display("FAIL %s: got out=%b, want out=%b (cyc=%0d)", e_m.nm, ov, e_m.v, cyc);
                    end
                    if (e_m.tol >= 0) begin
                        n_cmp++;
                        if (cyc < e_m.cyc - e_m.tol || cyc > e_m.cyc + e_m.tol) begin
                            n_bad++;
                            $display("FAIL %s_time: got cyc=%0d, want cyc=%0d +-%0d",
                                     e_m.nm, cyc, e_m.cyc, e_m.tol);
                        end
                    end
                end
                prev = ov;
            end
        end
    end

    initial begin
        rstn_i     = 1'b1;
        fast_req_i = 1'b0;
        lock_en    = 1'b1;
        lock_kill  = 1'b0;
        push(vec(1, 0, 0, 0, 0, 0), 0, -1, "reset_values");
        #1 rstn_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #3 rstn_i = 1'b1;

        push(vec(0, 0, 0, 0, 0, 0), 16,  0, "pll_rst_pulse");
        push(vec(0, 0, 0, 0, 1, 0), 113, 1, "sd_rstn_release");
        push(vec(0, 1, 0, 1, 1, 0), 121, 1, "first_ready");
        drain(400, "bringup");

        switch_to(1'b1);
        switch_to(1'b0);

        step();
        k = cyc;
        lock_kill = 1'b1;
        step();
        step();
        fast_req_i = 1'b1;
        push(vec(1, 0, 0, 0, 1, 1), k + 3,         0, "lockloss_in_run");
        push(vec(0, 0, 0, 0, 1, 1), k + 19,        0, "relock_pulse_end");
        push(vec(0, 0, 1, 0, 1, 1), k + 19 + 96,   0, "sel_after_relock");
        push(vec(0, 1, 1, 1, 1, 1), k + 19 + 104,  0, "ready_after_relock");
        step();
        step();
        step();
        step();
        lock_kill = 1'b0;
        drain(400, "relock");

        step();
        k = cyc;
        fast_req_i = 1'b0;
        push(vec(0, 0, 1, 0, 1, 1), k + 1, 0,  "gate_off_before_reset");
        push(vec(1, 0, 0, 0, 0, 0), 0,     -1, "async_reset");
        step();
        step();
        step();
        @(posedge clk_i);
        #3 rstn_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #3 rstn_i = 1'b1;

        push(vec(0, 0, 0, 0, 0, 0), 16,  0, "restart_pulse");
        push(vec(0, 0, 0, 0, 1, 0), 130, 0, "sd_rstn_after_glitch");
        push(vec(0, 1, 0, 1, 1, 0), 138, 0, "ready_after_glitch");
        for (int i = 0; i < 200 && cyc < 60; i++) step();
        lock_kill = 1'b1;
        step();
        step();
        step();
        lock_kill = 1'b0;
        drain(400, "glitch");

        step();
        k = cyc;
        lock_en = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            push(vec(1, 0, 0, 0, 1, (j > 15) ? 15 : j), k + 3 + (j - 1) * 4112, 0, "timeout_rise");
            if (j < 16)
                push(vec(0, 0, 0, 0, 1, j), k + 3 + (j - 1) * 4112 + 16, 0, "timeout_fall");
        end
        drain(64000, "timeout");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
